// File: rtl/zeptron_pkg.sv
// Shared Zeptron pipeline types and constants.
package zeptron_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            epoch;
  } fetch_tag_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with first-word-fall-through read; DEPTH must be a power of two.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Zeptron instruction fetch: owns the PC, tracks in-flight imem requests by epoch,
// and queues returned instructions for decode.
module fetch_stage
  import zeptron_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            f_valid,
  output logic [XLEN-1:0] f_instr,
  output logic [XLEN-1:0] f_pc,
  output logic [XLEN-1:0] f_pc_plus4,
  input  logic            d_ready
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [XLEN-1:0] pc;
  logic            epoch;

  fetch_tag_t      tag_in;
  fetch_tag_t      tag_head;
  logic            tag_push;
  logic            tag_pop;
  logic            tag_full;
  logic            tag_empty;
  logic [CW-1:0]   outstanding;

  fetch_entry_t    q_in;
  fetch_entry_t    q_head;
  logic            q_push;
  logic            q_pop;
  logic            q_full;
  logic            q_empty;
  logic [CW-1:0]   q_count;

  logic            grant;
  logic            resp_keep;
  logic [CW:0]     in_use;

  // Handshakes: imem request transfers when imem_req & imem_gnt; decode transfer
  // when f_valid & d_ready; f_valid/f_instr/f_pc stay stable while f_valid & !d_ready.
  assign f_valid = ~reset & ~redirect & ~q_empty;
  assign q_pop   = f_valid & d_ready;

  // Credit covers both in-flight requests and queued entries, so the queue never overflows.
  assign in_use   = {1'b0, outstanding} + {1'b0, q_count} - {{CW{1'b0}}, q_pop};
  assign imem_req = ~reset & ~redirect & ~tag_full & (in_use < (CW+1)'(BUF_DEPTH));
  assign grant    = imem_req & imem_gnt;

  assign tag_push  = grant;
  assign tag_in    = '{pc: pc, epoch: epoch};
  assign tag_pop   = imem_rvalid & ~tag_empty;
  assign resp_keep = tag_pop & (tag_head.epoch == epoch) & ~redirect;
  assign q_push    = resp_keep & (~q_full | q_pop);
  assign q_in      = '{instr: imem_rdata, pc: tag_head.pc};

  assign imem_addr  = reset ? RESET_PC : pc;
  assign f_instr    = f_valid ? q_head.instr : NOP_INSTR;
  assign f_pc       = f_valid ? q_head.pc : '0;
  assign f_pc_plus4 = f_pc + 32'd4;

  // The tag FIFO occupancy is the outstanding-request count.
  fetch_fifo #(
    .WIDTH ($bits(fetch_tag_t)),
    .DEPTH (BUF_DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tag_push),
    .pop   (tag_pop),
    .clear (1'b0),
    .din   (tag_in),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (outstanding)
  );

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (BUF_DEPTH)
  ) u_instr_queue (
    .clk   (clk),
    .reset (reset),
    .push  (q_push),
    .pop   (q_pop),
    .clear (redirect),
    .din   (q_in),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // Redirect flips the epoch so responses already in flight are recognised as stale.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      epoch <= 1'b0;
    end else if (redirect) begin
      pc    <= redirect_pc & ~32'h0000_0003;
      epoch <= ~epoch;
    end else if (grant) begin
      pc    <= pc + 32'd4;
    end
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the Zeptron pipeline, sitting directly upstream of decode. It owns the program counter and issues word requests to instruction memory over a request/grant/response handshake. It buffers returned instructions in a small in-order queue and presents one instruction per cycle, with its PC and PC+4, to decode under a valid/ready handshake. Redirects from execute (taken branch, jal, jalr) flush the queue and discard in-flight responses using an epoch tag.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- BUF_DEPTH, 2, instruction-queue entries and maximum in-flight memory requests (power of two, ≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- imem_req  out  1  request valid
- imem_addr  out  32  word-aligned fetch address (= pc)
- imem_gnt  in  1  request accepted this cycle (only meaningful with imem_req)
- imem_rvalid  in  1  response valid; responses return in request order, ≥1 cycle after grant
- imem_rdata  in  32  response instruction word
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new PC; bits [1:0] ignored (treated as 0)
- f_valid  out  1  instruction available to decode
- f_instr  out  32  instruction; NOP (32'h0000_0013) when f_valid=0
- f_pc  out  32  PC of f_instr
- f_pc_plus4  out  32  f_pc + 4, modulo 2^32
- d_ready  in  1  decode accepts current instruction

## Operation
- State: pc, epoch bit, tag FIFO (pc + epoch per in-flight request, BUF_DEPTH entries), instruction queue (instr + pc, BUF_DEPTH entries).
- Reset: pc=RESET_PC, epoch=0, both FIFOs empty, outstanding=0. Outputs during and after reset cycle: imem_req=0, f_valid=0, f_instr=NOP, f_pc=0, f_pc_plus4=4, imem_addr=RESET_PC.
- pop = f_valid & d_ready. Issue credit: imem_req = !reset & !redirect & (outstanding + queue_count − pop < BUF_DEPTH).
- Grant (imem_req & imem_gnt): push {pc, epoch} to tag FIFO; pc <= pc + 4 (wraps 32'hFFFF_FFFC → 0); outstanding+1.
- Response (imem_rvalid): pop tag FIFO; outstanding−1; if tag epoch == current epoch and no redirect this cycle, push {imem_rdata, tag pc} to queue, else drop.
- Queue head drives f_instr/f_pc directly; f_valid = queue non-empty & !redirect.
- Redirect: pc <= {redirect_pc[31:2],2'b00}; epoch toggles; queue cleared; no request issued; f_valid=0 that cycle; pop suppressed. Tag FIFO and outstanding unchanged — stale responses drain and are dropped by epoch mismatch.
- Redirect and reset simultaneous: reset wins.
- Response with empty tag FIFO is a protocol error; ignore the response and leave state unchanged (assertion in bench).
- imem_rvalid with imem_req/gnt in same cycle: both processed; counters net correctly.
- Credit rule guarantees queue never overflows; no backpressure on imem_rvalid.

## Timing
- Grant at cycle N, rvalid at N+k → f_valid at N+k+1 (queue is registered, no bypass).
- 1-cycle memory, d_ready held high: one instruction per cycle sustained after 3-cycle startup (reset low at cycle 0: req at 0, rvalid 1, f_valid 2).
- Redirect at cycle R: first request to new PC at R+1; earliest f_valid for it at R+3 with 1-cycle memory.
- d_ready low: outputs held stable while f_valid=1; requests stop once credit exhausted.

## Structure
- Shared package zeptron_pkg: XLEN=32, NOP_INSTR=32'h0000_0013, RESET_PC default constant, fetch_entry_t struct {instr, pc} and fetch_tag_t {pc, epoch}.
- One sub-module: fetch_fifo, parameterized synchronous FIFO (width, depth, push, pop, clear, full, empty, count), instantiated twice (tag FIFO without clear, instruction queue with clear).

## Test plan
- Reset release, 1-cycle memory returning addr as data, d_ready=1 -> f_pc 0,4,8,… on consecutive cycles from cycle 2; f_pc_plus4 = f_pc+4; no gaps.
- d_ready low 5 cycles mid-stream -> f_instr/f_pc frozen, imem_req drops after 2 outstanding+queued, no instruction lost or duplicated on resume.
- Redirect to 32'h0000_0103 while 2 requests in flight (3-cycle memory) -> both stale responses dropped, next f_pc = 32'h0000_0100, then 0x104.
- Redirect same cycle as f_valid & d_ready and an rvalid -> nothing popped or pushed; f_valid=0 that cycle.
- Mid-stream reset with requests outstanding -> all outputs at reset values next cycle; fetch restarts at RESET_PC.
- pc at 32'hFFFF_FFF8 -> fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; f_pc_plus4 of 0xFFFF_FFFC is 0.
